// File: rtl/leb128_stream_dec_if.sv
// Byte-stream in / decoded-value out bundle for the LEB128 decoder.
//   slave  : decoder side (consumes bytes, produces values)
//   master : fetch/parser side (drives bytes, accepts values)
// Signals: signed_i, in_data[7:0], in_valid, in_ready,
//          out_data[WIDTH-1:0], out_len[LENW-1:0], out_err, out_valid, out_ready
interface leb128_stream_dec_if #(
  parameter int WIDTH = 32
);
  localparam int MAXLEN = (WIDTH + 6) / 7;
  localparam int LENW   = $clog2(MAXLEN + 1);

  logic             signed_i;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [LENW-1:0]  out_len;
  logic             out_err;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  signed_i, in_data, in_valid, out_ready,
    output in_ready, out_data, out_len, out_err, out_valid
  );

  modport master (
    output signed_i, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_len, out_err, out_valid
  );
endinterface

// File: rtl/leb128_stream_dec.sv
// Streaming LEB128 decoder, one byte per cycle sustained.
// Bytes arrive over io.in_* (valid/ready); each value (unsigned or signed,
// chosen by io.signed_i on its first byte) is assembled into an accumulator
// and emitted through a single output register io.out_* (valid/ready) with
// its byte length and an error flag.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   io     - leb128_stream_dec_if.slave (byte stream in, value out)
// STRICT=1 additionally flags final bytes whose unused high bits do not fit
// in WIDTH; over-long codes (MAXLEN bytes, still continuing) always flag.
module leb128_stream_dec #(
  parameter int WIDTH  = 32,
  parameter bit STRICT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  leb128_stream_dec_if.slave io
);
  localparam int MAXLEN = (WIDTH + 6) / 7;
  localparam int LENW   = $clog2(MAXLEN + 1);
  localparam int ACCW   = 7 * MAXLEN;
  // payload bits of the last byte that still land inside WIDTH
  localparam int USED   = WIDTH - 7 * (MAXLEN - 1);
  localparam logic [LENW-1:0] LAST = LENW'(MAXLEN - 1);

  logic [LENW-1:0]  cnt;
  logic [WIDTH-1:0] acc;
  logic             mode_q;

  logic [WIDTH-1:0] out_data_q;
  logic [LENW-1:0]  out_len_q;
  logic             out_err_q;
  logic             out_valid_q;

  logic             in_ready;
  logic             accept;
  logic             mode;
  logic             last_byte;
  logic             term;
  logic [ACCW-1:0]  shifted;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] ext;
  logic             rng_err;
  logic             err;

  // single output register: a pop in the same cycle frees the slot
  assign in_ready  = !out_valid_q || io.out_ready;
  assign accept    = io.in_valid && in_ready;
  assign mode      = (cnt == '0) ? io.signed_i : mode_q;
  assign last_byte = (cnt == LAST);
  assign term      = !io.in_data[7] || last_byte;

  always_comb begin
    shifted  = {{(ACCW-7){1'b0}}, io.in_data[6:0]} << (7 * int'(cnt));
    acc_next = acc | shifted[WIDTH-1:0];

    // sign fill above the last payload bit; empty once 7(k+1) >= WIDTH
    ext = '0;
    for (int i = 0; i < WIDTH; i++)
      ext[i] = (i >= 7 * (int'(cnt) + 1));
    if (!(mode && io.in_data[6]))
      ext = '0;

    // out-of-range bits of the final byte
    rng_err = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!mode && i >= USED && io.in_data[i])
        rng_err = 1'b1;
      if (mode && i >= USED - 1 && io.in_data[i] != io.in_data[6])
        rng_err = 1'b1;
    end

    err = last_byte && (io.in_data[7] || (STRICT && rng_err));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      mode_q <= 1'b0;
    end else if (accept) begin
      if (term) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        acc <= acc_next;
      end
      if (cnt == '0)
        mode_q <= io.signed_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_len_q   <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept && term) begin
      out_data_q  <= acc_next | ext;
      out_len_q   <= cnt + 1'b1;
      out_err_q   <= err;
      out_valid_q <= 1'b1;
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_data  = out_data_q;
  assign io.out_len   = out_len_q;
  assign io.out_err   = out_err_q;
  assign io.out_valid = out_valid_q;
endmodule

// File: tb/tb_leb128_stream_dec.sv
module tb_leb128_stream_dec;
  logic clk;
  logic rst_n;
  logic       signed_i;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  leb128_stream_dec_if #(.WIDTH(32)) if0 ();
  leb128_stream_dec_if #(.WIDTH(32)) if1 ();

  assign if0.signed_i  = signed_i;
  assign if0.in_data   = in_data;
  assign if0.in_valid  = in_valid;
  assign if0.out_ready = out_ready;
  assign if1.signed_i  = signed_i;
  assign if1.in_data   = in_data;
  assign if1.in_valid  = in_valid;
  assign if1.out_ready = out_ready;

  leb128_stream_dec #(.WIDTH(32), .STRICT(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .io(if0));
  leb128_stream_dec #(.WIDTH(32), .STRICT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .io(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, data, len, err}
  function automatic logic [36:0] o0();
    return {if0.out_valid, if0.out_data, if0.out_len, if0.out_err};
  endfunction
  function automatic logic [36:0] o1();
    return {if1.out_valid, if1.out_data, if1.out_len, if1.out_err};
  endfunction

  // present one byte at a negedge, wait (bounded) for acceptance,
  // return at the following negedge with in_valid dropped
  task automatic put(input logic [7:0] b, input logic s);
    int n = 0;
    in_data  = b;
    signed_i = s;
    in_valid = 1'b1;
    while (!if0.in_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      n_cmp++; n_bad++;
      $display("FAIL put_timeout got in_ready=0 want 1");
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; signed_i = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (o0() !== 37'd0) begin n_bad++; $display("FAIL reset_out0 got %h want %h", o0(), 37'd0); end
    n_cmp++;
    if (o1() !== 37'd0) begin n_bad++; $display("FAIL reset_out1 got %h want %h", o1(), 37'd0); end
    n_cmp++;
    if (if0.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", if0.in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero();
    put(8'h00, 1'b0);
    n_cmp++;
    if (o0() !== {1'b1, 32'd0, 3'd1, 1'b0}) begin n_bad++; $display("FAIL u_zero got %h want %h", o0(), {1'b1, 32'd0, 3'd1, 1'b0}); end
    @(negedge clk);
    n_cmp++;
    if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL pop_clear got %b want 0", if0.out_valid); end
    put(8'h00, 1'b1);
    n_cmp++;
    if (o0() !== {1'b1, 32'd0, 3'd1, 1'b0}) begin n_bad++; $display("FAIL s_zero got %h want %h", o0(), {1'b1, 32'd0, 3'd1, 1'b0}); end
    @(negedge clk);
  endtask

  task automatic test_multibyte();
    put(8'h9b, 1'b1); put(8'hf1, 1'b0); put(8'h59, 1'b0);   // mode latched on 1st byte
    n_cmp++;
    if (o0() !== {1'b1, 32'hFFF6_789B, 3'd3, 1'b0}) begin n_bad++; $display("FAIL s_624485 got %h want %h", o0(), {1'b1, 32'hFFF6_789B, 3'd3, 1'b0}); end
    @(negedge clk);
    put(8'he5, 1'b0); put(8'h8e, 1'b1); put(8'h26, 1'b1);
    n_cmp++;
    if (o0() !== {1'b1, 32'd624485, 3'd3, 1'b0}) begin n_bad++; $display("FAIL u_624485 got %h want %h", o0(), {1'b1, 32'd624485, 3'd3, 1'b0}); end
    @(negedge clk);
  endtask

  task automatic test_strict();
    put(8'hff, 1'b1); put(8'hff, 1'b1); put(8'hff, 1'b1); put(8'hff, 1'b1); put(8'h0f, 1'b1);
    n_cmp++;
    if (o0() !== {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b0}) begin n_bad++; $display("FAIL lax_0f got %h want %h", o0(), {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b0}); end
    n_cmp++;
    if (o1() !== {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b1}) begin n_bad++; $display("FAIL strict_0f got %h want %h", o1(), {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b1}); end
    @(negedge clk);
    put(8'hff, 1'b1); put(8'hff, 1'b1); put(8'hff, 1'b1); put(8'hff, 1'b1); put(8'h7f, 1'b1);
    n_cmp++;
    if (o1() !== {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b0}) begin n_bad++; $display("FAIL strict_7f got %h want %h", o1(), {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b0}); end
    @(negedge clk);
    // unsigned 5-byte with 0f is in range for 32 bits
    put(8'h80, 1'b0); put(8'h80, 1'b0); put(8'h80, 1'b0); put(8'h80, 1'b0); put(8'h0f, 1'b0);
    n_cmp++;
    if (o1() !== {1'b1, 32'hF000_0000, 3'd5, 1'b0}) begin n_bad++; $display("FAIL strict_u0f got %h want %h", o1(), {1'b1, 32'hF000_0000, 3'd5, 1'b0}); end
    @(negedge clk);
  endtask

  task automatic test_overlong();
    put(8'hff, 1'b0); put(8'hff, 1'b0); put(8'hff, 1'b0); put(8'hff, 1'b0); put(8'hff, 1'b0);
    n_cmp++;
    if (o0() !== {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b1}) begin n_bad++; $display("FAIL overlong0 got %h want %h", o0(), {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b1}); end
    n_cmp++;
    if (o1() !== {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b1}) begin n_bad++; $display("FAIL overlong1 got %h want %h", o1(), {1'b1, 32'hFFFF_FFFF, 3'd5, 1'b1}); end
    @(negedge clk);
    put(8'h01, 1'b0);
    n_cmp++;
    if (o0() !== {1'b1, 32'd1, 3'd1, 1'b0}) begin n_bad++; $display("FAIL after_overlong got %h want %h", o0(), {1'b1, 32'd1, 3'd1, 1'b0}); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    put(8'h7f, 1'b0);
    n_cmp++;
    if (o0() !== {1'b1, 32'd127, 3'd1, 1'b0}) begin n_bad++; $display("FAIL b2b_127 got %h want %h", o0(), {1'b1, 32'd127, 3'd1, 1'b0}); end
    out_ready = 1'b0;
    in_data = 8'h80; signed_i = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({if0.in_ready, o0()} !== {1'b0, 1'b1, 32'd127, 3'd1, 1'b0}) begin
        n_bad++; $display("FAIL stall_%0d got rdy=%b %h want rdy=0 %h", i, if0.in_ready, o0(), {1'b1, 32'd127, 3'd1, 1'b0});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);                   // 127 popped, 80 accepted
    n_cmp++;
    if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap got %b want 0", if0.out_valid); end
    in_data = 8'h01;
    @(negedge clk);
    n_cmp++;
    if (o0() !== {1'b1, 32'd128, 3'd2, 1'b0}) begin n_bad++; $display("FAIL b2b_128 got %h want %h", o0(), {1'b1, 32'd128, 3'd2, 1'b0}); end
    in_data = 8'h00;                  // terminates while 128 pops
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if (o0() !== {1'b1, 32'd0, 3'd1, 1'b0}) begin n_bad++; $display("FAIL b2b_0 got %h want %h", o0(), {1'b1, 32'd0, 3'd1, 1'b0}); end
    @(negedge clk);
    n_cmp++;
    if (if0.out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b want 0", if0.out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    put(8'h01, 1'b0);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o0() !== 37'd0) begin n_bad++; $display("FAIL rst_pending got %h want %h", o0(), 37'd0); end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    put(8'h9b, 1'b1); put(8'hf1, 1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o0() !== 37'd0) begin n_bad++; $display("FAIL rst_mid got %h want %h", o0(), 37'd0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    put(8'h05, 1'b0);
    n_cmp++;
    if (o0() !== {1'b1, 32'd5, 3'd1, 1'b0}) begin n_bad++; $display("FAIL rst_then5 got %h want %h", o0(), {1'b1, 32'd5, 3'd1, 1'b0}); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_multibyte();
    test_strict();
    test_overlong();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
